uart_wb_host: RTL
=================

UART_WB_HOST -- requirements
Module: uart_wb_host

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width of data and response.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 The block SHALL have parameter BAUD_RATE, default 9600, UART bit rate.
REQ-004 The block SHALL have parameter CLOCK_FREQ, default 50000000, clk frequency in Hz; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer division.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, response wait limit in clk cycles.
REQ-006 Ports SHALL be as follows:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle, accepts command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  ADDR_WIDTH  target word address.
- cmd_dat  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_dat  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- busy  out  1  transaction in progress.
- uart_tx  out  1  serial line to bridge.
- uart_rx  in  1  serial line from bridge, asynchronous.

Function
REQ-007 The block SHALL act as the host-side initiator of the UART-to-Wishbone bridge protocol: it sends commands to the bridge and collects the bridge's responses.
REQ-008 UART framing SHALL be 8N1: idle high, one start bit (0), 8 data bits LSB first, one stop bit (1), each held for CLKS_PER_BIT cycles.
REQ-009 A command SHALL be accepted on a cycle where cmd_valid=1 and cmd_ready=1; cmd_we, cmd_adr and cmd_dat SHALL be captured that cycle.
REQ-010 cmd_ready SHALL equal 1 only in state IDLE; busy SHALL equal NOT cmd_ready.
REQ-011 A write frame SHALL be 9 bytes: 0x57, then cmd_adr MSB-byte first (4 bytes), then cmd_dat MSB-byte first (4 bytes).
REQ-012 A read frame SHALL be 5 bytes: 0x52, then cmd_adr MSB-byte first.
REQ-013 Bytes SHALL be sent back-to-back: the next start bit begins the cycle after the previous stop bit ends.
REQ-014 The state machine SHALL use these states and transitions:
- IDLE -> TX on accept.
- TX -> RX_WAIT after the last stop bit.
- RX_WAIT -> DONE when the expected response is complete, or on timeout or error.
- DONE -> IDLE after one cycle.
REQ-015 The expected response SHALL be 1 byte (0x4B) for a write and 4 bytes (data, MSB-byte first) for a read.
REQ-016 The RX path SHALL pass uart_rx through a 2-flop synchronizer before use.
REQ-017 The RX path SHALL detect a start bit on a synchronized falling edge.
REQ-018 The RX path SHALL re-sample the start bit at CLKS_PER_BIT/2 cycles and return to line-idle hunting if it is high (glitch).
REQ-019 The RX path SHALL sample each data bit and the stop bit at its mid-point.
REQ-020 A low stop bit SHALL set the error flag and end the transaction.
REQ-021 A write response byte other than 0x4B SHALL set the error flag.
REQ-022 Bytes arriving on uart_rx while in IDLE or TX SHALL be discarded.
REQ-023 The timeout counter SHALL start at RX_WAIT entry and reset on every completed received byte; reaching TIMEOUT_CYCLES SHALL set the error flag.
REQ-024 In DONE, rsp_valid SHALL be 1 for exactly one cycle, rsp_err SHALL hold the error flag, and rsp_dat SHALL hold the assembled read data (0 for writes or on error).
REQ-025 rsp_dat and rsp_err SHALL hold their values until the next DONE.
REQ-026 cmd_valid asserted while busy SHALL be ignored; no queueing.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL go to IDLE regardless of state, including mid-byte on TX or RX.
REQ-028 On reset, outputs SHALL be: uart_tx=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_dat=0.
REQ-029 On reset, all counters, shift registers and synchronizer flops SHALL clear (synchronizer flops to 1).
REQ-030 A partially sent frame SHALL NOT resume after reset.

Verification (CLOCK_FREQ=80, BAUD_RATE=10, CLKS_PER_BIT=8, TIMEOUT_CYCLES=400)
REQ-031 Write 0x00000010 <- 0xDEADBEEF, rx model replies 0x4B -> tx bytes 57 00 00 00 10 DE AD BE EF, each 80 cycles, back-to-back; rsp_valid one cycle, rsp_err=0, rsp_dat=0.
REQ-032 Read 0x00000004, rx model replies 12 34 56 78 -> tx bytes 52 00 00 00 04; rsp_dat=0x12345678, rsp_err=0.
REQ-033 Read with no reply -> rsp_valid exactly 400 cycles after RX_WAIT entry, rsp_err=1, rsp_dat=0; cmd_ready=1 the following cycle.
REQ-034 Write, reply 0x4B with stop bit driven 0 -> rsp_err=1; reply 0x4E -> rsp_err=1.
REQ-035 3-cycle low glitch on uart_rx in RX_WAIT, then a valid 0x4B -> glitch ignored, rsp_err=0.
REQ-036 rst asserted at the 3rd tx byte's bit 4 -> next cycle uart_tx=1, cmd_ready=1; a new read then completes normally; cmd_valid pulsed while busy has no effect.

Source files
------------

// File: rtl/uart_wb_host.sv
// Host-side initiator for the UART-to-Wishbone bridge: serialises read/write
// command frames over 8N1 UART and collects the bridge's response bytes.
module uart_wb_host #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCK_FREQ     = 50000000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_adr,
  input  logic [DATA_WIDTH-1:0] cmd_dat,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_dat,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  uart_tx,
  input  logic                  uart_rx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TX      = 2'd1;
  localparam logic [1:0] RX_WAIT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state;
  logic          we;
  logic [71:0]   tx_frame;
  logic [7:0]    tx_byte;
  logic [3:0]    tx_left;
  logic [3:0]    tx_phase;
  logic [CW-1:0] tx_cnt;
  logic          rx_p0, rx_p1, rx_p2;
  logic          rx_active;
  logic [3:0]    rx_phase;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_sh;
  logic [1:0]    rx_count;
  logic [23:0]   rd_sh;
  logic [TW-1:0] tmo_cnt;
  logic          rx_done;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state == DONE);
  assign tx_byte   = tx_frame[71:64];
  assign rx_done   = (state == RX_WAIT) && rx_active && (rx_phase == 4'd9) && (rx_cnt == BIT_LAST);

  // Phase 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit.
  always_comb begin
    uart_tx = 1'b1;
    if (state == TX) begin
      case (tx_phase)
        4'd0:    uart_tx = 1'b0;
        4'd9:    uart_tx = 1'b1;
        default: uart_tx = tx_byte[3'(tx_phase - 4'd1)];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we        <= 1'b0;
      tx_frame  <= '0;
      tx_left   <= '0;
      tx_phase  <= '0;
      tx_cnt    <= '0;
      rx_p0     <= 1'b1;
      rx_p1     <= 1'b1;
      rx_p2     <= 1'b1;
      rx_active <= 1'b0;
      rx_phase  <= '0;
      rx_cnt    <= '0;
      rx_sh     <= '0;
      rx_count  <= '0;
      rd_sh     <= '0;
      tmo_cnt   <= '0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            we       <= cmd_we;
            tx_frame <= cmd_we ? {8'h57, 32'(cmd_adr), 32'(cmd_dat)}
                               : {8'h52, 32'(cmd_adr), 32'h0};
            tx_left  <= cmd_we ? 4'd9 : 4'd5;
            tx_phase <= '0;
            tx_cnt   <= '0;
            state    <= TX;
          end
        end
        TX: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_phase == 4'd9) begin
              tx_phase <= '0;
              tx_frame <= {tx_frame[63:0], 8'h00};
              tx_left  <= tx_left - 4'd1;
              if (tx_left == 4'd1) begin
                state     <= RX_WAIT;
                tmo_cnt   <= '0;
                rx_active <= 1'b0;
                rx_count  <= '0;
                rd_sh     <= '0;
              end
            end else begin
              tx_phase <= tx_phase + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          // Start bit is re-checked at half a bit so a short low glitch is dropped.
          if (!rx_active) begin
            if (rx_p2 && !rx_p1) begin
              rx_active <= 1'b1;
              rx_cnt    <= '0;
              rx_phase  <= '0;
            end
          end else if (rx_phase == 4'd0) begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt <= '0;
              if (rx_p1) rx_active <= 1'b0;
              else       rx_phase  <= 4'd1;
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end else if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_phase == 4'd9) begin
              rx_active <= 1'b0;
            end else begin
              rx_sh    <= {rx_p1, rx_sh[7:1]};
              rx_phase <= rx_phase + 4'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end

          if (rx_done) begin
            tmo_cnt <= '0;
            if (!rx_p1) begin
              state   <= DONE;
              rsp_err <= 1'b1;
              rsp_dat <= '0;
            end else if (we) begin
              state   <= DONE;
              rsp_err <= (rx_sh != 8'h4B);
              rsp_dat <= '0;
            end else begin
              rd_sh    <= {rd_sh[15:0], rx_sh};
              rx_count <= rx_count + 2'd1;
              if (rx_count == 2'd3) begin
                state   <= DONE;
                rsp_err <= 1'b0;
                rsp_dat <= DATA_WIDTH'({rd_sh, rx_sh});
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= DONE;
            rsp_err <= 1'b1;
            rsp_dat <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
